// File: rtl/sort_engine_ctrl.sv
// sort_engine_ctrl: buffers N signed 16-bit samples, bubble-sorts them with early exit, streams them out
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data      input sample stream, accepted while in_ready (LOAD only)
//   in_ready              registered, high only in LOAD
//   out_valid/out_data    sorted sample stream (DRAIN only), held while out_ready is low
//   out_ready             downstream accept
//   busy                  high while sorting
//   swaps                 swap count of the last sort, saturating at 255
// Build option: define SORT_DESCEND_EN for descending order (default ascending).
module sort_engine_ctrl #(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic [7:0]  swaps
);
  localparam int PW = $clog2(N);
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] SORT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, i_q, i_d, pass_q, pass_d, ip1;
  logic in_ready_q, in_ready_d, out_valid_q, out_valid_d, pass_swapped_q, pass_swapped_d;
  logic [7:0] swaps_q, swaps_d;
  logic signed [15:0] mem_q [N];
  logic signed [15:0] mem_d [N];
  logic signed [15:0] a, b;
  logic do_swap, swapped_any;
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    i_d            = i_q;
    pass_d         = pass_q;
    in_ready_d     = in_ready_q;
    out_valid_d    = out_valid_q;
    pass_swapped_d = pass_swapped_q;
    swaps_d        = swaps_q;
    mem_d          = mem_q;
    ip1            = i_q + PW'(1);
    a              = mem_q[i_q];
    b              = mem_q[ip1];
`ifdef SORT_DESCEND_EN
    do_swap        = (state_q == SORT) && (b > a);
`else
    do_swap        = (state_q == SORT) && (a > b);
`endif
    // the last compare of a pass still counts toward the early-exit decision
    swapped_any    = pass_swapped_q | do_swap;
    case (state_q)
      LOAD: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          mem_d[wr_ptr_q] = in_data;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (wr_ptr_q == PW'(N-1)) begin
            state_d        = SORT;
            in_ready_d     = 1'b0;
            wr_ptr_d       = '0;
            i_d            = '0;
            pass_d         = '0;
            swaps_d        = '0;
            pass_swapped_d = 1'b0;
          end
        end
      end
      SORT: begin
        if (do_swap) begin
          mem_d[i_q] = b;
          mem_d[ip1] = a;
          swaps_d = (swaps_q == 8'hFF) ? swaps_q : swaps_q + 8'd1;
        end
        if (i_q == PW'(N-2)) begin
          if (!swapped_any || pass_q == PW'(N-2)) begin
            state_d     = DRAIN;
            out_valid_d = 1'b1;
          end else begin
            i_d            = '0;
            pass_d         = pass_q + PW'(1);
            pass_swapped_d = 1'b0;
          end
        end else begin
          i_d            = ip1;
          pass_swapped_d = swapped_any;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          if (rd_ptr_q == PW'(N-1)) begin
            state_d     = LOAD;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= LOAD;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      i_q            <= '0;
      pass_q         <= '0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      pass_swapped_q <= 1'b0;
      swaps_q        <= '0;
      mem_q          <= '{default: '0};
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      i_q            <= i_d;
      pass_q         <= pass_d;
      in_ready_q     <= in_ready_d;
      out_valid_q    <= out_valid_d;
      pass_swapped_q <= pass_swapped_d;
      swaps_q        <= swaps_d;
      mem_q          <= mem_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign busy      = (state_q == SORT);
  assign swaps     = swaps_q;
endmodule
